// File: rtl/cnn_pkg.sv
// Shared CNN definitions: default geometry, output-size helpers and the
// assembler FSM state encoding.
package cnn_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int H_DEF          = 32;
    localparam int W_DEF          = 32;
    localparam int F_DEF          = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } fma_state_e;

    // Valid-convolution output size for an input dimension and filter size.
    function automatic int out_dim(input int in_dim, input int f);
        return in_dim - f + 1;
    endfunction

    function automatic int half_dim(input int ow);
        return ow / 2;
    endfunction

endpackage

// File: rtl/feature_map_assembler_if.sv
// Half-row segment handshake between a convolution engine (master) and the
// feature map assembler (slave).
interface feature_map_assembler_if
    import cnn_pkg::*;
#(
    parameter int SEG_W = half_dim(out_dim(W_DEF, F_DEF)) * DATA_WIDTH_DEF
) ();

    logic             in_valid;
    logic             in_ready;
    logic [0:SEG_W-1] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/relu_lane.sv
// One element lane in front of the feature map write port. Clamps negative
// values to zero when FMA_RELU_EN is defined, otherwise passes through.
module relu_lane
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic signed [DATA_WIDTH-1:0] din,
    output logic signed [DATA_WIDTH-1:0] dout
);

`ifdef FMA_RELU_EN
    function automatic logic signed [DATA_WIDTH-1:0] relu(input logic signed [DATA_WIDTH-1:0] x);
        return (x < 0) ? '0 : x;
    endfunction

    assign dout = relu(din);
`else
    assign dout = din;
`endif

endmodule

// File: rtl/feature_map_assembler.sv
// Collects half-row segments into a flattened D x OH x OW feature map.
// Optional macro FMA_RELU_EN clamps negative elements to zero before storing.
module feature_map_assembler
    import cnn_pkg::*;
#(
    parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter  int D          = 1,
    parameter  int H          = H_DEF,
    parameter  int W          = W_DEF,
    parameter  int F          = F_DEF,
    localparam int OH         = out_dim(H, F),
    localparam int OW         = out_dim(W, F),
    localparam int HALF       = half_dim(OW),
    localparam int LANES      = D * HALF,
    localparam int FM_W       = D * OH * OW * DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    feature_map_assembler_if.slave seg,
    output logic [5:0]             rowNumber,
    output logic [5:0]             column,
    output logic [0:FM_W-1]        feature_map,
    output logic                   done
);

    fma_state_e      state_q, state_d;
    logic [5:0]      row_q, row_d;
    logic            col_q, col_d;
    logic            done_q, done_d;
    logic [0:FM_W-1] fmap_q, fmap_d;

    logic signed [DATA_WIDTH-1:0] lane_in  [LANES];
    logic signed [DATA_WIDTH-1:0] lane_out [LANES];

    // Lane i carries segment element (k,c) with i = k*HALF + c.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign lane_in[i] = seg.in_data[i*DATA_WIDTH +: DATA_WIDTH];

        relu_lane #(.DATA_WIDTH(DATA_WIDTH)) u_relu_lane (
            .din  (lane_in[i]),
            .dout (lane_out[i])
        );
    end

    assign seg.in_ready = (state_q == COLLECT);
    assign rowNumber    = row_q;
    assign column       = {5'd0, col_q};
    assign feature_map  = fmap_q;
    assign done         = done_q;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        done_d  = done_q;
        fmap_d  = fmap_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    row_d   = '0;
                    col_d   = 1'b0;
                    done_d  = 1'b0;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (seg.in_valid) begin
                    for (int i = 0; i < LANES; i++) begin
                        fmap_d[((i / HALF) * OH * OW + int'(row_q) * OW
                                + int'(col_q) * HALF + (i % HALF)) * DATA_WIDTH +: DATA_WIDTH]
                            = lane_out[i];
                    end
                    // The last segment parks the position at (OH-1, 1) until restarted.
                    if (!col_q) begin
                        col_d = 1'b1;
                    end else if (row_q == 6'(OH - 1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        row_d = row_q + 6'd1;
                        col_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= 1'b0;
            done_q  <= 1'b0;
            fmap_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            done_q  <= done_d;
            fmap_q  <= fmap_d;
        end
    end

endmodule

// File: doc/feature_map_assembler.md
FEATURE_MAP_ASSEMBLER -- requirements
Module: feature_map_assembler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of one signed feature value.
REQ-002 SHALL have parameter D, default 1, number of feature-map channels.
REQ-003 SHALL have parameter H, default 32, input image height.
REQ-004 SHALL have parameter W, default 32, input image width.
REQ-005 SHALL have parameter F, default 5, filter size; derived OH=H-F+1, OW=W-F+1, HALF=OW/2.
REQ-006 SHALL have port clk  input  1  single clock, all logic on its rising edge.
REQ-007 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port start  input  1  begin assembling one frame.
REQ-009 SHALL have port in_valid  input  1  in_data holds one half-row segment.
REQ-010 SHALL have port in_ready  output  1  assembler accepts a segment this cycle.
REQ-011 SHALL have port in_data  input  [0:HALF*D*DATA_WIDTH-1]  segment; element (k,c) at bit offset (k*HALF+c)*DATA_WIDTH, MSB-first.
REQ-012 SHALL have port rowNumber  output  [5:0]  output row of the next expected segment.
REQ-013 SHALL have port column  output  [5:0]  half of the next expected segment: 0 = columns 0..HALF-1, 1 = columns HALF..OW-1.
REQ-014 SHALL have port feature_map  output  [0:D*OH*OW*DATA_WIDTH-1]  flattened result, element (k,r,c) at offset (k*OH*OW+r*OW+c)*DATA_WIDTH.
REQ-015 SHALL have port done  output  1  frame complete, held until next start or reset.

Function
REQ-016 SHALL implement FSM states IDLE, COLLECT, DONE.
REQ-017 SHALL in IDLE or DONE on start=1 zero rowNumber and column, clear done, enter COLLECT next cycle.
REQ-018 SHALL drive in_ready=1 only in COLLECT, combinationally from state.
REQ-019 SHALL on in_valid&&in_ready write each element (k,c) of in_data to feature_map element (k, rowNumber, column*HALF+c) at the same clock edge.
REQ-020 SHALL after an accepted segment with column=0 set column=1; with column=1 set column=0 and increment rowNumber.
REQ-021 SHALL on acceptance at rowNumber=OH-1, column=1 enter DONE, set done=1, hold rowNumber=OH-1, column=1.
REQ-022 SHALL ignore start while in COLLECT; in_valid while in IDLE/DONE has no effect.
REQ-023 SHALL leave feature_map elements not written in the current frame at their prior values; feature_map stable in DONE.
REQ-024 SHALL accept back-to-back segments, one per cycle, so a frame takes exactly 2*OH accepting cycles (56 at defaults).
REQ-025 SHALL tolerate in_valid gaps of any length without state change.

Reset
REQ-026 SHALL on reset=1 at any clock edge, including mid-frame, force IDLE, rowNumber=0, column=0, done=0, feature_map all zeros; in_ready=0.
REQ-027 SHALL give reset priority over start and in_valid in the same cycle.

Configuration
REQ-028 SHALL with FMA_RELU_EN defined clamp each element whose signed value is negative to 0 before writing; non-negative values unchanged.
REQ-029 SHALL with FMA_RELU_EN undefined write in_data elements unmodified.

Structure
REQ-030 SHALL take DATA_WIDTH, H, W, F defaults and OH/OW/HALF derivations and FSM state encodings from shared package cnn_pkg.
REQ-031 SHALL instantiate one sub-module relu_lane per element (pass-through when FMA_RELU_EN undefined).

Verification
REQ-032 SHALL cover: reset, start, 56 back-to-back segments, element c of segment n = n*16+c -> feature_map(r,c') = (2r+c'/14)*16+c'%14, done=1 after 56th accept.
REQ-033 SHALL cover: in_valid toggling 1/0 every cycle -> identical feature_map to REQ-032, done after 111 cycles from first accept.
REQ-034 SHALL cover: reset asserted after 20 segments -> state IDLE, feature_map all 0, done=0, rowNumber=0, column=0 next cycle.
REQ-035 SHALL cover: start pulsed during COLLECT at row 5 -> ignored, rowNumber continues 5 -> 6.
REQ-036 SHALL cover: with FMA_RELU_EN, element 16'hFFF0 -> stored 0, 16'h0010 -> stored 16'h0010; without, 16'hFFF0 stored.
REQ-037 SHALL cover: start in DONE, second frame with distinct values -> done drops next cycle, every element overwritten.
